// File: rtl/flags_stack.sv
// ============================================================================
// Module      : flags_stack
// Description : CPU status-flag register with a LIFO shadow stack for nested
//               interrupts, plus sticky overflow/underflow error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flags_stack #(
    parameter  int NUM_FLAGS  = 2,
    parameter  int SHAD_DEPTH = 4,
    localparam int CW         = $clog2(SHAD_DEPTH + 1)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NUM_FLAGS-1:0] FLG_CLR,
    input  logic [NUM_FLAGS-1:0] FLG_SET,
    input  logic [NUM_FLAGS-1:0] FLG_LD,
    input  logic [NUM_FLAGS-1:0] FLG_D,
    input  logic                 SHAD_PUSH,
    input  logic                 SHAD_POP,
    input  logic                 ERR_CLR,
    output logic [NUM_FLAGS-1:0] FLAGS,
    output logic [CW-1:0]        DEPTH,
    output logic                 EMPTY,
    output logic                 FULL,
    output logic                 ERR_OVF,
    output logic                 ERR_UNF
);

    localparam logic [CW-1:0] C_DEPTH_MAX = CW'(SHAD_DEPTH);

    logic [NUM_FLAGS-1:0] flags_q, flags_d;
    logic [CW-1:0]        depth_q, depth_d;
    logic                 empty_q, full_q;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic [NUM_FLAGS-1:0] stack_q [SHAD_DEPTH];

    logic                 push_ok, pop_ok, swap, restore;
    logic [NUM_FLAGS-1:0] flg_upd;
    logic [NUM_FLAGS-1:0] top;
    logic [SHAD_DEPTH-1:0] wr_en;

    assign push_ok = SHAD_PUSH & ~SHAD_POP & ~full_q;
    assign pop_ok  = SHAD_POP & ~SHAD_PUSH & ~empty_q;
    assign swap    = SHAD_PUSH & SHAD_POP & ~empty_q;
    assign restore = pop_ok | swap;

    // A push writes the slot above the top; a swap overwrites the top itself.
    generate
        for (genvar i = 0; i < SHAD_DEPTH; i++) begin : g_wr
            assign wr_en[i] = (push_ok && (depth_q == CW'(i))) ||
                              (swap    && (depth_q == CW'(i + 1)));
        end
    endgenerate

    always_comb begin
        flg_upd = flags_q;
        for (int i = 0; i < NUM_FLAGS; i++) begin
            if (FLG_CLR[i])      flg_upd[i] = 1'b0;
            else if (FLG_SET[i]) flg_upd[i] = 1'b1;
            else if (FLG_LD[i])  flg_upd[i] = FLG_D[i];
        end
    end

    always_comb begin
        top = '0;
        for (int i = 0; i < SHAD_DEPTH; i++) begin
            if (depth_q == CW'(i + 1)) top = stack_q[i];
        end
    end

    always_comb begin
        flags_d = restore ? top : flg_upd;
        depth_d = depth_q;
        if (push_ok)     depth_d = depth_q + CW'(1);
        else if (pop_ok) depth_d = depth_q - CW'(1);
        // A new error event takes precedence over a coincident clear.
        ovf_d = (SHAD_PUSH & ~SHAD_POP & full_q) | (ovf_q & ~ERR_CLR);
        unf_d = (SHAD_POP & empty_q) | (unf_q & ~ERR_CLR);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            flags_q <= '0;
            depth_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            depth_q <= depth_d;
            empty_q <= (depth_d == '0);
            full_q  <= (depth_d == C_DEPTH_MAX);
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < SHAD_DEPTH; i++) begin
            if (wr_en[i]) stack_q[i] <= flags_q;
        end
    end

    assign FLAGS   = flags_q;
    assign DEPTH   = depth_q;
    assign EMPTY   = empty_q;
    assign FULL    = full_q;
    assign ERR_OVF = ovf_q;
    assign ERR_UNF = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_flags_stack.sv
// ============================================================================
// Module      : tb_flags_stack
// Description : Directed vector bench for flags_stack (2x4 and 4x1 configs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flags_stack;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [1:0] clr, set, ld, d;
    logic       push, pop, ec;
    logic [1:0] flags;
    logic [2:0] depth;
    logic       empty, full, ovf, unf;

    logic [3:0] clr2, set2, ld2, d2;
    logic       push2, pop2, ec2;
    logic [3:0] flags2;
    logic [0:0] depth2;
    logic       empty2, full2, ovf2, unf2;

    int checks = 0;
    int errors = 0;

    flags_stack #(.NUM_FLAGS(2), .SHAD_DEPTH(4)) u_dut (
        .CLK(clk), .RST_N(rst_n),
        .FLG_CLR(clr), .FLG_SET(set), .FLG_LD(ld), .FLG_D(d),
        .SHAD_PUSH(push), .SHAD_POP(pop), .ERR_CLR(ec),
        .FLAGS(flags), .DEPTH(depth), .EMPTY(empty), .FULL(full),
        .ERR_OVF(ovf), .ERR_UNF(unf)
    );

    flags_stack #(.NUM_FLAGS(4), .SHAD_DEPTH(1)) u_dut2 (
        .CLK(clk), .RST_N(rst_n),
        .FLG_CLR(clr2), .FLG_SET(set2), .FLG_LD(ld2), .FLG_D(d2),
        .SHAD_PUSH(push2), .SHAD_POP(pop2), .ERR_CLR(ec2),
        .FLAGS(flags2), .DEPTH(depth2), .EMPTY(empty2), .FULL(full2),
        .ERR_OVF(ovf2), .ERR_UNF(unf2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] clr, set, ld, d;
        logic       push, pop, ec;
        logic [1:0] e_flags;
        int         e_depth;
        logic       e_empty, e_full, e_ovf, e_unf;
    } vec_t;

    localparam int NV = 34;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [1:0] c, s, l, dd,
                                input logic pu, po, e,
                                input logic [1:0] ef, input int ed,
                                input logic ee, efu, eo, eu);
        vec_t v;
        v.clr = c; v.set = s; v.ld = l; v.d = dd;
        v.push = pu; v.pop = po; v.ec = e;
        v.e_flags = ef; v.e_depth = ed;
        v.e_empty = ee; v.e_full = efu; v.e_ovf = eo; v.e_unf = eu;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_main(input string tag, input logic [1:0] ef, input int ed,
                              input logic ee, efu, eo, eu);
        check({tag, ".FLAGS"},   int'(flags), int'(ef));
        check({tag, ".DEPTH"},   int'(depth), ed);
        check({tag, ".EMPTY"},   int'(empty), int'(ee));
        check({tag, ".FULL"},    int'(full),  int'(efu));
        check({tag, ".ERR_OVF"}, int'(ovf),   int'(eo));
        check({tag, ".ERR_UNF"}, int'(unf),   int'(eu));
    endtask

    task automatic step(input logic [1:0] c, s, l, dd, input logic pu, po, e);
        @(negedge clk);
        clr = c; set = s; ld = l; d = dd; push = pu; pop = po; ec = e;
        @(posedge clk);
        #1;
        clr = '0; set = '0; ld = '0; d = '0; push = 1'b0; pop = 1'b0; ec = 1'b0;
    endtask

    task automatic step2(input logic [3:0] l, dd, input logic pu, po);
        @(negedge clk);
        ld2 = l; d2 = dd; push2 = pu; pop2 = po;
        @(posedge clk);
        #1;
        ld2 = '0; d2 = '0; push2 = 1'b0; pop2 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr = '0; set = '0; ld = '0; d = '0; push = 1'b0; pop = 1'b0; ec = 1'b0;
        clr2 = '0; set2 = '0; ld2 = '0; d2 = '0; push2 = 1'b0; pop2 = 1'b0; ec2 = 1'b0;

        //              clr    set    ld     d      pu  po  ec   flags  dp  E  F  O  U
        vecs[0]  = mk(2'b01,2'b11,2'b11,2'b00, 0,0,0, 2'b10,0, 1,0,0,0);
        vecs[1]  = mk(2'b00,2'b00,2'b11,2'b01, 0,0,0, 2'b01,0, 1,0,0,0);
        vecs[2]  = mk(2'b00,2'b00,2'b00,2'b00, 1,0,0, 2'b01,1, 0,0,0,0);
        vecs[3]  = mk(2'b00,2'b00,2'b11,2'b10, 0,0,0, 2'b10,1, 0,0,0,0);
        vecs[4]  = mk(2'b00,2'b00,2'b00,2'b00, 1,0,0, 2'b10,2, 0,0,0,0);
        vecs[5]  = mk(2'b00,2'b00,2'b11,2'b11, 0,0,0, 2'b11,2, 0,0,0,0);
        vecs[6]  = mk(2'b00,2'b00,2'b00,2'b00, 0,1,0, 2'b10,1, 0,0,0,0);
        vecs[7]  = mk(2'b00,2'b00,2'b00,2'b00, 0,1,0, 2'b01,0, 1,0,0,0);
        vecs[8]  = mk(2'b00,2'b00,2'b11,2'b00, 0,0,0, 2'b00,0, 1,0,0,0);
        vecs[9]  = mk(2'b00,2'b00,2'b11,2'b01, 1,0,0, 2'b01,1, 0,0,0,0);
        vecs[10] = mk(2'b00,2'b00,2'b11,2'b10, 1,0,0, 2'b10,2, 0,0,0,0);
        vecs[11] = mk(2'b00,2'b00,2'b11,2'b11, 1,0,0, 2'b11,3, 0,0,0,0);
        vecs[12] = mk(2'b00,2'b00,2'b11,2'b01, 1,0,0, 2'b01,4, 0,1,0,0);
        vecs[13] = mk(2'b00,2'b00,2'b00,2'b00, 1,0,0, 2'b01,4, 0,1,1,0);
        vecs[14] = mk(2'b00,2'b00,2'b00,2'b00, 0,1,0, 2'b11,3, 0,0,1,0);
        vecs[15] = mk(2'b00,2'b00,2'b00,2'b00, 0,1,0, 2'b10,2, 0,0,1,0);
        vecs[16] = mk(2'b00,2'b00,2'b00,2'b00, 0,1,0, 2'b01,1, 0,0,1,0);
        vecs[17] = mk(2'b00,2'b00,2'b00,2'b00, 0,1,0, 2'b00,0, 1,0,1,0);
        vecs[18] = mk(2'b00,2'b10,2'b00,2'b00, 0,1,0, 2'b10,0, 1,0,1,1);
        vecs[19] = mk(2'b00,2'b00,2'b00,2'b00, 0,0,1, 2'b10,0, 1,0,0,0);
        vecs[20] = mk(2'b00,2'b00,2'b00,2'b00, 0,1,1, 2'b10,0, 1,0,0,1);
        vecs[21] = mk(2'b00,2'b00,2'b00,2'b00, 0,0,1, 2'b10,0, 1,0,0,0);
        vecs[22] = mk(2'b00,2'b00,2'b11,2'b00, 0,0,0, 2'b00,0, 1,0,0,0);
        vecs[23] = mk(2'b00,2'b00,2'b11,2'b11, 1,0,0, 2'b11,1, 0,0,0,0);
        vecs[24] = mk(2'b00,2'b00,2'b11,2'b01, 0,0,0, 2'b01,1, 0,0,0,0);
        vecs[25] = mk(2'b00,2'b00,2'b00,2'b00, 1,0,0, 2'b01,2, 0,0,0,0);
        vecs[26] = mk(2'b00,2'b11,2'b00,2'b00, 0,1,0, 2'b01,1, 0,0,0,0);
        vecs[27] = mk(2'b00,2'b00,2'b00,2'b00, 1,0,0, 2'b01,2, 0,0,0,0);
        vecs[28] = mk(2'b00,2'b00,2'b11,2'b10, 0,0,0, 2'b10,2, 0,0,0,0);
        vecs[29] = mk(2'b11,2'b00,2'b00,2'b00, 1,1,0, 2'b01,2, 0,0,0,0);
        vecs[30] = mk(2'b00,2'b00,2'b00,2'b00, 0,1,0, 2'b10,1, 0,0,0,0);
        vecs[31] = mk(2'b00,2'b00,2'b00,2'b00, 0,1,0, 2'b00,0, 1,0,0,0);
        vecs[32] = mk(2'b00,2'b01,2'b00,2'b00, 1,1,0, 2'b01,0, 1,0,0,1);
        vecs[33] = mk(2'b00,2'b00,2'b00,2'b00, 0,0,1, 2'b01,0, 1,0,0,0);

        repeat (2) @(posedge clk);
        #1;
        check_main("reset", 2'b00, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].clr, vecs[i].set, vecs[i].ld, vecs[i].d,
                 vecs[i].push, vecs[i].pop, vecs[i].ec);
            check_main($sformatf("vec%0d", i), vecs[i].e_flags, vecs[i].e_depth,
                       vecs[i].e_empty, vecs[i].e_full, vecs[i].e_ovf, vecs[i].e_unf);
        end

        // Build DEPTH=3 with ERR_OVF set, then reset asynchronously mid-cycle.
        step(2'b00, 2'b00, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        check_main("pre_areset", 2'b11, 3, 1'b0, 1'b0, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check_main("areset", 2'b00, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-level, 4-flag instance.
        check("d2.reset.EMPTY", int'(empty2), 1);
        check("d2.reset.DEPTH", int'(depth2), 0);
        step2(4'b1111, 4'b0001, 1'b0, 1'b0);
        check("d2.ld.FLAGS", int'(flags2), 1);
        step2(4'b0000, 4'b0000, 1'b1, 1'b0);
        check("d2.push.DEPTH", int'(depth2), 1);
        check("d2.push.FULL", int'(full2), 1);
        check("d2.push.EMPTY", int'(empty2), 0);
        step2(4'b1111, 4'b1010, 1'b0, 1'b0);
        check("d2.ld2.FLAGS", int'(flags2), 10);
        step2(4'b0000, 4'b0000, 1'b1, 1'b0);
        check("d2.ovf.ERR_OVF", int'(ovf2), 1);
        check("d2.ovf.DEPTH", int'(depth2), 1);
        check("d2.ovf.FLAGS", int'(flags2), 10);
        step2(4'b0000, 4'b0000, 1'b0, 1'b1);
        check("d2.pop.FLAGS", int'(flags2), 1);
        check("d2.pop.DEPTH", int'(depth2), 0);
        check("d2.pop.EMPTY", int'(empty2), 1);
        check("d2.pop.FULL", int'(full2), 0);
        check("d2.pop.ERR_UNF", int'(unf2), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/flags_stack.md
# flags_stack

Parametrised CPU status-flag register with a hardware shadow stack for nested interrupts. It holds NUM_FLAGS flags, bit 0 = C and bit 1 = Z by default. Each flag has independent clear, set and load controls. Flag state can be pushed on interrupt entry and popped on RETIE, up to SHAD_DEPTH nesting levels, with sticky overflow and underflow error reporting. It sits between the ALU and the control unit, and it replaces the single-level C/Z flag block in the RAT datapath.

## Interface
- NUM_FLAGS, 2, number of status flags; bit 0 = C, bit 1 = Z, higher bits are user flags
- SHAD_DEPTH, 4, shadow stack entries (nesting levels), ≥ 1
- CW, $clog2(SHAD_DEPTH+1), width of the DEPTH output (derived; not overridden)

Ports:
- CLK  in  1  system clock, all state changes on rising edge
- RST_N  in  1  asynchronous, active-low reset
- FLG_CLR  in  NUM_FLAGS  per-flag clear
- FLG_SET  in  NUM_FLAGS  per-flag set
- FLG_LD  in  NUM_FLAGS  per-flag load from FLG_D
- FLG_D  in  NUM_FLAGS  new flag values from ALU (bit 0 = C, bit 1 = Z)
- SHAD_PUSH  in  1  save current flags to shadow stack (interrupt entry)
- SHAD_POP  in  1  restore flags from shadow stack (RETIE)
- ERR_CLR  in  1  clear sticky error bits
- FLAGS  out  NUM_FLAGS  current flag register (C_FLAG = FLAGS[0], Z_FLAG = FLAGS[1])
- DEPTH  out  CW  occupied shadow entries, 0..SHAD_DEPTH
- EMPTY  out  1  DEPTH == 0
- FULL  out  1  DEPTH == SHAD_DEPTH
- ERR_OVF  out  1  sticky: push attempted while FULL
- ERR_UNF  out  1  sticky: pop attempted while EMPTY

## Operation
- Reset (RST_N low, asynchronous):
  - FLAGS = 0, DEPTH = 0, EMPTY = 1, FULL = 0, ERR_OVF = 0, ERR_UNF = 0.
  - Stack contents are don't-care.
- Per-flag update when no restore occurs. Priority is CLR > SET > LD > hold, evaluated independently per bit.
- Push (SHAD_PUSH=1, SHAD_POP=0, not FULL):
  - stack[DEPTH] ← FLAGS, using the pre-update value for this cycle; DEPTH+1.
  - Flag updates in the same cycle still apply to FLAGS.
- Pop (SHAD_POP=1, SHAD_PUSH=0, not EMPTY):
  - FLAGS ← stack[DEPTH-1]; DEPTH-1.
  - Restore overrides all CLR/SET/LD that cycle.
- Push and pop together, not EMPTY (swap):
  - FLAGS ← stack[DEPTH-1], and stack[DEPTH-1] ← pre-update FLAGS.
  - DEPTH unchanged; CLR/SET/LD ignored.
- Push and pop together while EMPTY:
  - Both ignored; ERR_UNF ← 1; CLR/SET/LD apply normally.
- Push while FULL (no pop):
  - Push dropped; stack and DEPTH unchanged.
  - ERR_OVF ← 1; CLR/SET/LD apply normally.
- Pop while EMPTY (no push):
  - FLAGS follow CLR/SET/LD; DEPTH stays 0; ERR_UNF ← 1.
- Error bits:
  - ERR_CLR clears both error bits.
  - If ERR_CLR coincides with a new error event, the error set wins.
- Stack is LIFO, indexed by DEPTH. There is no wrap-around and entries are never overwritten beyond the top.

## Timing
- All outputs are registered. FLAGS, DEPTH, EMPTY, FULL and the error bits reflect a cycle's inputs after the next rising CLK edge (latency 1).
- No combinational path from any input to any output.
- Push/pop throughput is one operation per cycle. Back-to-back push-push, pop-pop and push-pop are legal.
- RST_N assertion mid-operation clears state immediately, without waiting for CLK.
- Deassertion is synchronised externally. The first update occurs on the first CLK edge with RST_N high.

## Test plan
- Reset then priority: FLG_CLR=01, FLG_SET=11, FLG_LD=11, FLG_D=00 in one cycle -> FLAGS=10. Next cycle FLG_LD=11, FLG_D=01 -> FLAGS=01.
- Nesting: FLAGS=01, push; set FLAGS=10, push; set FLAGS=11, pop -> FLAGS=10, DEPTH=1; pop -> FLAGS=01, DEPTH=0, EMPTY=1.
- Overflow: SHAD_DEPTH=4, push 5 times with distinct FLAGS (00,01,10,11,01) -> DEPTH=4, FULL=1, ERR_OVF=1. Four pops return 11,10,01,00 in order.
- Underflow and error clear: pop while EMPTY with FLG_SET=10 -> FLAGS=10, DEPTH=0, ERR_UNF=1. ERR_CLR -> ERR_UNF=0. ERR_CLR with a simultaneous empty pop -> ERR_UNF stays 1.
- Simultaneous events:
  - Push with FLG_LD=11, FLG_D=11 while FLAGS=00 -> stored entry 00, FLAGS=11.
  - Pop with FLG_SET=11 while top=01 -> FLAGS=01.
  - Push+pop with FLAGS=10, top=01 -> FLAGS=01, top=10, DEPTH unchanged.
- Async reset: drop RST_N between clock edges at DEPTH=3, ERR_OVF=1 -> all outputs reach reset values before the next edge. With NUM_FLAGS=4, SHAD_DEPTH=1, repeat the nesting test -> FULL asserts after 1 push.
